// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes
// and the frame builder used by the host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // Bits shifted out LSB first after the start bit: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pads with a falling-edge
// strobe on the synchronized clock. Shared by the receive and transmit paths.
module ps2_sync_edge (
    input  logic clk,
    input  logic res,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Reset to the idle (pulled-up) level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            clk_ff   <= '1;
            data_ff  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2clk_in};
            data_ff  <= {data_ff[0], ps2data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte
// with odd parity, collects the device ack and reports done/error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_drive_low,
    output logic       ps2data_drive_low
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state, state_n;
    logic [9:0]       shreg, shreg_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
    logic             err_q, err_n;
    logic             ready_n, done_n, err_out_n;
    logic             clk_drv_n, data_drv_n;
    logic             clk_sync, data_sync, clk_fall;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .res        (res),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        inh_cnt_n  = inh_cnt;
        wd_cnt_n   = wd_cnt;
        err_n      = err_q;
        done_n     = 1'b0;
        err_out_n  = 1'b0;
        data_drv_n = ps2data_drive_low;

        unique case (state)
            IDLE: begin
                data_drv_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    shreg_n   = ps2_frame(tx_data);
                    bit_cnt_n = '0;
                    inh_cnt_n = '0;
                    err_n     = 1'b0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_n = inh_cnt + 1'b1;
                if (inh_cnt == INH_LAST) begin
                    data_drv_n = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                wd_cnt_n = '0;
                state_n  = BITS;
            end
            BITS: begin
                wd_cnt_n = wd_cnt + 1'b1;
                // Registered update: data moves the cycle after the detected edge.
                if (clk_fall) begin
                    data_drv_n = ~shreg[0];
                    shreg_n    = {1'b1, shreg[9:1]};
                    bit_cnt_n  = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                wd_cnt_n = wd_cnt + 1'b1;
                if (clk_fall) begin
                    err_n     = data_sync;
                    bit_cnt_n = bit_cnt + 4'd1;
                    state_n   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                wd_cnt_n = wd_cnt + 1'b1;
                if (clk_sync && data_sync) begin
                    done_n    = 1'b1;
                    err_out_n = err_q;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if ((state == BITS || state == ACK || state == WAIT_IDLE) &&
            wd_cnt == WD_LAST && state_n != IDLE) begin
            state_n    = IDLE;
            data_drv_n = 1'b0;
            done_n     = 1'b1;
            err_out_n  = 1'b1;
        end

        clk_drv_n = (state_n == INHIBIT) || (state_n == START);
        // Ready comes back one cycle after the done pulse.
        ready_n   = (state_n == IDLE) && (state == IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state             <= IDLE;
            shreg             <= '0;
            bit_cnt           <= '0;
            inh_cnt           <= '0;
            wd_cnt            <= '0;
            err_q             <= 1'b0;
            tx_ready          <= 1'b1;
            tx_done           <= 1'b0;
            tx_err            <= 1'b0;
            ps2clk_drive_low  <= 1'b0;
            ps2data_drive_low <= 1'b0;
        end else begin
            state             <= state_n;
            shreg             <= shreg_n;
            bit_cnt           <= bit_cnt_n;
            inh_cnt           <= inh_cnt_n;
            wd_cnt            <= wd_cnt_n;
            err_q             <= err_n;
            tx_ready          <= ready_n;
            tx_done           <= done_n;
            tx_err            <= err_out_n;
            ps2clk_drive_low  <= clk_drv_n;
            ps2data_drive_low <= data_drv_n;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple device
// model that clocks frames, samples bits on rising edges and drives the ack.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       res;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_drive_low, ps2data_drive_low;
    logic       dev_clk_low, dev_data_low;

    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;

    assign ps2clk_in  = ~(ps2clk_drive_low | dev_clk_low);
    assign ps2data_in = ~(ps2data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .res               (res),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .tx_done           (tx_done),
        .tx_err            (tx_err),
        .ps2clk_in         (ps2clk_in),
        .ps2data_in        (ps2data_in),
        .ps2clk_drive_low  (ps2clk_drive_low),
        .ps2data_drive_low (ps2data_drive_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Returns on the first cycle with data held low and clock released.
    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < int'(INH) + 20; i++) begin
            if (ps2data_drive_low && !ps2clk_drive_low) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_start_seen"}, 32'(ok), 1);
        check({tag, "_start_bit"}, 32'(ps2data_in), 0);
    endtask

    task automatic dev_pulse(output logic s);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        s = ps2data_in;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic dev_bits(input int n, output logic [9:0] b);
        logic s;
        b = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dev_pulse(s);
            b[i] = s;
        end
    endtask

    // Eleventh clock; leaves the clock released and the ack level still driven.
    task automatic dev_ack_pulse(input logic ack);
        dev_data_low = ack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(seen), 1);
        check({tag, "_err"}, 32'(tx_err), 32'(exp_err));
        check({tag, "_ready_at_done"}, 32'(tx_ready), 0);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(tx_ready), 1);
        check({tag, "_done_width"}, 32'(tx_done), 0);
        check({tag, "_lines_idle"}, 32'({ps2clk_drive_low, ps2data_drive_low}), 0);
    endtask

    initial begin
        logic [9:0]  b;
        int unsigned n;
        int unsigned dc;
        int unsigned rel_cyc;

        res = 1'b1; tx_valid = 1'b0; tx_data = '0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        #1;
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_done", 32'(tx_done), 0);
        check("rst_err", 32'(tx_err), 0);
        check("rst_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 0);
        repeat (3) @(negedge clk);
        res = 1'b0;
        repeat (3) @(negedge clk);

        // ED with ack: inhibit length, start phase, bit order, odd parity.
        send(CMD_SET_LEDS);
        check("ed_ready_drop", 32'(tx_ready), 0);
        n = 0;
        while (ps2clk_drive_low && !ps2data_drive_low && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("ed_inhibit_len", n, INH);
        check("ed_start_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'b11);
        @(negedge clk);
        check("ed_clk_released", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'b01);
        check("ed_start_bit", 32'(ps2data_in), 0);
        dev_bits(10, b);
        check("ed_frame", 32'(b), 32'h3ED);
        dev_ack_pulse(1'b1);
        dev_data_low = 1'b0;
        wait_done("ed", 1'b0, 20);

        // 00 with the ack withheld.
        repeat (5) @(negedge clk);
        send(8'h00);
        wait_start("zero");
        dev_bits(10, b);
        check("zero_frame", 32'(b), 32'h300);
        dev_ack_pulse(1'b0);
        wait_done("zero", 1'b1, 20);

        // Device never clocks: watchdog fires TMO cycles after clock release.
        repeat (5) @(negedge clk);
        send(CMD_ENABLE);
        wait_start("tmo");
        rel_cyc = cyc;
        wait_done("tmo", 1'b1, int'(TMO) + 20);
        check("tmo_latency", done_cyc - rel_cyc, TMO);

        // Reset after the fourth edge, then a clean FF frame.
        repeat (5) @(negedge clk);
        send(8'h00);
        wait_start("mid");
        dev_bits(4, b);
        check("mid_pre_data", 32'(ps2data_drive_low), 1);
        dc = done_cnt;
        res = 1'b1;
        #1;
        check("mid_rst_lines", 32'({ps2clk_drive_low, ps2data_drive_low}), 0);
        check("mid_rst_ready", 32'(tx_ready), 1);
        check("mid_rst_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        res = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_no_done", done_cnt, dc);
        send(CMD_RESET);
        wait_start("ff");
        dev_bits(10, b);
        check("ff_frame", 32'(b), 32'h3FF);
        dev_ack_pulse(1'b1);
        dev_data_low = 1'b0;
        wait_done("ff", 1'b0, 20);

        // tx_valid held through the frame while tx_data changes.
        repeat (5) @(negedge clk);
        dc = done_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = CMD_ENABLE;
        @(negedge clk);
        tx_data  = 8'h12;
        wait_start("hold");
        dev_bits(10, b);
        check("hold_frame", 32'(b), 32'h2F4);
        check("hold_ready_low", 32'(tx_ready), 0);
        dev_ack_pulse(1'b1);
        dev_data_low = 1'b0;
        wait_done("hold", 1'b0, 20);
        @(negedge clk);
        check("hold_second_accept", 32'({tx_ready, ps2clk_drive_low}), 32'b01);
        tx_valid = 1'b0;
        check("hold_one_done", done_cnt - dc, 1);
        wait_start("second");
        dev_bits(10, b);
        check("second_frame", 32'(b), 32'h312);
        dev_ack_pulse(1'b1);
        dev_data_low = 1'b0;
        wait_done("second", 1'b0, 20);

        // Device keeps data low after the ack clock.
        repeat (5) @(negedge clk);
        send(BREAK_PREFIX);
        wait_start("slow");
        dev_bits(10, b);
        check("slow_frame", 32'(b), 32'h3F0);
        dc = done_cnt;
        dev_ack_pulse(1'b1);
        repeat (150) @(negedge clk);
        check("slow_no_done", done_cnt, dc);
        check("slow_ready_low", 32'(tx_ready), 0);
        dev_data_low = 1'b0;
        wait_done("slow", 1'b0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
